// File: rtl/sm4_keyctl_pkg.sv
`default_nettype none
// =============================================================================
// sm4_keyctl_pkg : shared types and constants for the SM4 key RAM controller
// Revision: 1.0
// =============================================================================
package sm4_keyctl_pkg;

  localparam int KEY_W  = 128;
  localparam int ADDR_W = 7;

  localparam logic [ADDR_W-1:0] RSV_A0 = 7'd32;
  localparam logic [ADDR_W-1:0] RSV_A1 = 7'd95;
  localparam logic [ADDR_W-1:0] RSV_A2 = 7'd127;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    DENY  = 3'd3,
    RESP  = 3'd4
  } keyctl_state_e;

  function automatic logic is_reserved(input logic [ADDR_W-1:0] addr);
    return (addr == RSV_A0) || (addr == RSV_A1) || (addr == RSV_A2);
  endfunction

endpackage
`default_nettype wire

// File: rtl/keyctl_rr_arb.sv
`default_nettype none
// =============================================================================
// keyctl_rr_arb : N-wide round-robin picker, pointer advances past the winner
// Revision: 1.0
// =============================================================================
module keyctl_rr_arb #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_win;
  logic [PW-1:0] w_idx;
  logic          w_found;
  int            idx;

  // Scan from the pointer upward, wrapping, and take the first requester.
  always_comb begin
    gnt     = '0;
    w_win   = '0;
    w_idx   = '0;
    w_found = 1'b0;
    idx     = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(r_ptr) + i;
      if (idx >= N) idx = idx - N;
      w_idx = PW'(idx);
      if (!w_found && req[w_idx]) begin
        w_found    = 1'b1;
        w_win      = w_idx;
        gnt[w_idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (en && w_found) begin
      r_ptr <= (w_win == PW'(N - 1)) ? '0 : w_win + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sm4_key_ram_ctrl.sv
`default_nettype none
// =============================================================================
// sm4_key_ram_ctrl : one-access-at-a-time arbiter/sequencer for the SM4 key RAM
// Revision: 1.0
// =============================================================================
module sm4_key_ram_ctrl
  import sm4_keyctl_pkg::*;
#(
  parameter int NUM_RD       = 2,
  parameter int WR_PRIORITY  = 1,
  parameter int RESERVED_CHK = 1,
  parameter int CNT_W        = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NUM_RD-1:0]        i_rd_req,
  input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
  output logic [NUM_RD-1:0]        o_rd_gnt,
  output logic [NUM_RD-1:0]        o_rd_done,
  output logic                     o_rd_err,
  output logic [KEY_W-1:0]         o_rd_key,
  input  logic                     i_wr_req,
  input  logic [ADDR_W-1:0]        i_wr_addr,
  input  logic [KEY_W-1:0]         i_wr_data,
  output logic                     o_wr_gnt,
  output logic                     o_wr_done,
  output logic                     o_wr_err,
  output logic                     o_ram_ren,
  output logic                     o_ram_wen,
  output logic [ADDR_W-1:0]        o_ram_addr,
  output logic [KEY_W-1:0]         o_ram_wdata,
  input  logic [KEY_W-1:0]         i_ram_key,
  input  logic                     i_ram_valid,
  input  logic                     i_ram_write_ack,
  output logic                     o_busy,
  output logic [CNT_W-1:0]         o_deny_cnt
);

  localparam int ARB_N = (WR_PRIORITY != 0) ? NUM_RD : NUM_RD + 1;

  keyctl_state_e r_state, w_state_nxt;

  logic              r_is_wr,    w_is_wr;
  logic [NUM_RD-1:0] r_rd_sel,   w_rd_sel;
  logic [NUM_RD-1:0] r_rd_gnt,   w_rd_gnt;
  logic [NUM_RD-1:0] r_rd_done,  w_rd_done;
  logic              r_rd_err,   w_rd_err;
  logic [KEY_W-1:0]  r_rd_key,   w_rd_key;
  logic              r_wr_gnt,   w_wr_gnt;
  logic              r_wr_done,  w_wr_done;
  logic              r_wr_err,   w_wr_err;
  logic              r_ram_ren,  w_ram_ren;
  logic              r_ram_wen,  w_ram_wen;
  logic [ADDR_W-1:0] r_ram_addr, w_ram_addr;
  logic [KEY_W-1:0]  r_ram_wdata, w_ram_wdata;
  logic              r_busy,     w_busy;
  logic [CNT_W-1:0]  r_deny_cnt, w_deny_cnt;

  logic [ARB_N-1:0]  w_arb_req;
  logic [ARB_N-1:0]  w_arb_gnt;
  logic              w_arb_en;
  logic              w_sel_wr;
  logic [NUM_RD-1:0] w_sel_rd;
  logic [ADDR_W-1:0] w_sel_addr;
  logic              w_any;
  logic              w_rsv;
  logic              w_finish;
  logic              w_fail;

  // With write priority the arbiter only sees reads; otherwise the write is its top slot.
  generate
    if (WR_PRIORITY != 0) begin : g_wr_prio
      assign w_arb_req = i_rd_req;
      assign w_arb_en  = (r_state == IDLE) && !i_wr_req;
      assign w_sel_wr  = i_wr_req;
      assign w_sel_rd  = i_wr_req ? '0 : w_arb_gnt;
    end else begin : g_wr_rr
      assign w_arb_req = {i_wr_req, i_rd_req};
      assign w_arb_en  = (r_state == IDLE);
      assign w_sel_wr  = w_arb_gnt[NUM_RD];
      assign w_sel_rd  = w_arb_gnt[NUM_RD-1:0];
    end
  endgenerate

  keyctl_rr_arb #(
    .N (ARB_N)
  ) u_arb (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .req   (w_arb_req),
    .en    (w_arb_en),
    .gnt   (w_arb_gnt)
  );

  always_comb begin
    w_sel_addr = i_wr_addr;
    if (!w_sel_wr) begin
      for (int k = 0; k < NUM_RD; k++) begin
        if (w_sel_rd[k]) w_sel_addr = i_rd_addr[k*ADDR_W +: ADDR_W];
      end
    end
  end

  assign w_any = w_sel_wr | (|w_sel_rd);
  assign w_rsv = (RESERVED_CHK != 0) && is_reserved(w_sel_addr);

  always_comb begin
    w_state_nxt = r_state;
    w_is_wr     = r_is_wr;
    w_rd_sel    = r_rd_sel;
    w_ram_addr  = r_ram_addr;
    w_ram_wdata = r_ram_wdata;
    w_rd_key    = r_rd_key;
    w_rd_gnt    = '0;
    w_wr_gnt    = 1'b0;
    w_ram_ren   = 1'b0;
    w_ram_wen   = 1'b0;
    w_rd_done   = '0;
    w_wr_done   = 1'b0;
    w_rd_err    = 1'b0;
    w_wr_err    = 1'b0;
    w_finish    = 1'b0;
    w_fail      = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_is_wr    = w_sel_wr;
          w_rd_sel   = w_sel_rd;
          w_ram_addr = w_sel_addr;
          if (w_sel_wr) w_ram_wdata = i_wr_data;
          w_rd_gnt   = w_sel_rd;
          w_wr_gnt   = w_sel_wr;
          if (w_rsv) begin
            w_state_nxt = DENY;
          end else begin
            w_state_nxt = ISSUE;
            w_ram_ren   = !w_sel_wr;
            w_ram_wen   = w_sel_wr;
          end
        end
      end
      ISSUE: w_state_nxt = WAIT;
      WAIT: begin
        w_state_nxt = RESP;
        w_finish    = 1'b1;
        w_fail      = r_is_wr ? !i_ram_write_ack : !i_ram_valid;
      end
      DENY: begin
        w_state_nxt = RESP;
        w_finish    = 1'b1;
        w_fail      = 1'b1;
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase

    // Completion is registered on entry to RESP so done/err/key appear together.
    if (w_finish) begin
      if (r_is_wr) begin
        w_wr_done = 1'b1;
        w_wr_err  = w_fail;
      end else begin
        w_rd_done = r_rd_sel;
        w_rd_err  = w_fail;
        w_rd_key  = w_fail ? '0 : i_ram_key;
      end
    end

    w_deny_cnt = r_deny_cnt;
    if (w_finish && w_fail && (r_deny_cnt != '1)) w_deny_cnt = r_deny_cnt + 1'b1;
    w_busy = (w_state_nxt != IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_is_wr     <= 1'b0;
      r_rd_sel    <= '0;
      r_rd_gnt    <= '0;
      r_rd_done   <= '0;
      r_rd_err    <= 1'b0;
      r_rd_key    <= '0;
      r_wr_gnt    <= 1'b0;
      r_wr_done   <= 1'b0;
      r_wr_err    <= 1'b0;
      r_ram_ren   <= 1'b0;
      r_ram_wen   <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_busy      <= 1'b0;
      r_deny_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_is_wr     <= w_is_wr;
      r_rd_sel    <= w_rd_sel;
      r_rd_gnt    <= w_rd_gnt;
      r_rd_done   <= w_rd_done;
      r_rd_err    <= w_rd_err;
      r_rd_key    <= w_rd_key;
      r_wr_gnt    <= w_wr_gnt;
      r_wr_done   <= w_wr_done;
      r_wr_err    <= w_wr_err;
      r_ram_ren   <= w_ram_ren;
      r_ram_wen   <= w_ram_wen;
      r_ram_addr  <= w_ram_addr;
      r_ram_wdata <= w_ram_wdata;
      r_busy      <= w_busy;
      r_deny_cnt  <= w_deny_cnt;
    end
  end

  assign o_rd_gnt    = r_rd_gnt;
  assign o_rd_done   = r_rd_done;
  assign o_rd_err    = r_rd_err;
  assign o_rd_key    = r_rd_key;
  assign o_wr_gnt    = r_wr_gnt;
  assign o_wr_done   = r_wr_done;
  assign o_wr_err    = r_wr_err;
  assign o_ram_ren   = r_ram_ren;
  assign o_ram_wen   = r_ram_wen;
  assign o_ram_addr  = r_ram_addr;
  assign o_ram_wdata = r_ram_wdata;
  assign o_busy      = r_busy;
  assign o_deny_cnt  = r_deny_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sm4_key_ram_ctrl.sv
`default_nettype none
// =============================================================================
// tb_sm4_key_ram_ctrl : directed vectors plus arbitration and reset sequences
// Revision: 1.0
// =============================================================================
module tb_sm4_key_ram_ctrl;

  localparam logic [127:0] K1 = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] K2 = 128'hDEADBEEFCAFEF00D1122334455667788;
  localparam logic [127:0] K3 = 128'hA5A5A5A55A5A5A5A0F0F0F0FF0F0F0F0;

  typedef struct {
    logic         wr;
    logic [1:0]   rd;
    logic [6:0]   addr;
    logic [127:0] wdata;
    logic         ok;
    logic [127:0] rkey;
    logic         exp_deny;
    logic         exp_err;
    logic [127:0] exp_key;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   rd_req;
  logic [13:0]  rd_addr;
  logic         wr_req;
  logic [6:0]   wr_addr;
  logic [127:0] wr_data;
  logic [127:0] ram_key;
  logic         ram_valid, ram_ack;

  logic [1:0]   rd_gnt, rd_done;
  logic         rd_err, wr_gnt, wr_done, wr_err, ram_ren, ram_wen, busy;
  logic [127:0] rd_key, ram_wdata;
  logic [6:0]   ram_addr;
  logic [15:0]  deny_cnt;

  logic [1:0]   s_rd_gnt, s_rd_done;
  logic         s_rd_err, s_wr_gnt, s_wr_done, s_wr_err, s_ram_ren, s_ram_wen, s_busy;
  logic [127:0] s_rd_key, s_ram_wdata;
  logic [6:0]   s_ram_addr;
  logic [1:0]   s_deny_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int exp_cnt  = 0;
  vec_t vecs[10];

  always #5 clk = ~clk;

  sm4_key_ram_ctrl dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rd_req(rd_req), .i_rd_addr(rd_addr),
    .o_rd_gnt(rd_gnt), .o_rd_done(rd_done), .o_rd_err(rd_err), .o_rd_key(rd_key),
    .i_wr_req(wr_req), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .o_wr_gnt(wr_gnt), .o_wr_done(wr_done), .o_wr_err(wr_err),
    .o_ram_ren(ram_ren), .o_ram_wen(ram_wen), .o_ram_addr(ram_addr), .o_ram_wdata(ram_wdata),
    .i_ram_key(ram_key), .i_ram_valid(ram_valid), .i_ram_write_ack(ram_ack),
    .o_busy(busy), .o_deny_cnt(deny_cnt)
  );

  // Narrow counter copy sharing all inputs, used to reach saturation quickly.
  sm4_key_ram_ctrl #(.CNT_W(2)) dut_sat (
    .i_clk(clk), .i_rst_n(rst_n), .i_rd_req(rd_req), .i_rd_addr(rd_addr),
    .o_rd_gnt(s_rd_gnt), .o_rd_done(s_rd_done), .o_rd_err(s_rd_err), .o_rd_key(s_rd_key),
    .i_wr_req(wr_req), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .o_wr_gnt(s_wr_gnt), .o_wr_done(s_wr_done), .o_wr_err(s_wr_err),
    .o_ram_ren(s_ram_ren), .o_ram_wen(s_ram_wen), .o_ram_addr(s_ram_addr), .o_ram_wdata(s_ram_wdata),
    .i_ram_key(ram_key), .i_ram_valid(ram_valid), .i_ram_write_ack(ram_ack),
    .o_busy(s_busy), .o_deny_cnt(s_deny_cnt)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic [1:0] rd, input logic [6:0] addr,
                              input logic [127:0] wdata, input logic ok, input logic [127:0] rkey,
                              input logic dny, input logic err, input logic [127:0] key);
    vec_t v;
    v.wr = wr; v.rd = rd; v.addr = addr; v.wdata = wdata; v.ok = ok; v.rkey = rkey;
    v.exp_deny = dny; v.exp_err = err; v.exp_key = key;
    return v;
  endfunction

  task automatic chk_cnt(input string name);
    chk({name, "_cnt"}, 128'(deny_cnt), 128'(exp_cnt));
    chk({name, "_sat"}, 128'(s_deny_cnt), 128'((exp_cnt > 3) ? 3 : exp_cnt));
  endtask

  task automatic run_vec(input int i, input vec_t v);
    string nm;
    nm = $sformatf("vec%0d", i);
    @(negedge clk);
    wr_req    = v.wr;
    wr_addr   = v.addr;
    wr_data   = v.wdata;
    rd_req    = v.rd;
    rd_addr   = {v.addr, v.addr};
    ram_key   = v.rkey;
    ram_valid = !v.wr && v.ok;
    ram_ack   = v.wr && v.ok;
    @(posedge clk); #1;
    chk({nm, "_rd_gnt"}, 128'(rd_gnt), 128'(v.wr ? 2'b00 : v.rd));
    chk({nm, "_wr_gnt"}, 128'(wr_gnt), 128'(v.wr));
    chk({nm, "_ren"}, 128'(ram_ren), 128'(!v.wr && !v.exp_deny));
    chk({nm, "_wen"}, 128'(ram_wen), 128'(v.wr && !v.exp_deny));
    if (!v.exp_deny) chk({nm, "_addr"}, 128'(ram_addr), 128'(v.addr));
    if (v.wr && !v.exp_deny) chk({nm, "_wdata"}, ram_wdata, v.wdata);
    chk({nm, "_busy"}, 128'(busy), 128'(1));
    wr_req = 1'b0;
    rd_req = 2'b00;
    if (!v.exp_deny) begin
      @(posedge clk); #1;
      chk({nm, "_strobe_off"}, 128'({ram_ren, ram_wen, wr_done, rd_done}), 128'(0));
    end
    @(posedge clk); #1;
    chk({nm, "_rd_done"}, 128'(rd_done), 128'(v.wr ? 2'b00 : v.rd));
    chk({nm, "_wr_done"}, 128'(wr_done), 128'(v.wr));
    chk({nm, "_err"}, 128'(v.wr ? wr_err : rd_err), 128'(v.exp_err));
    chk({nm, "_key"}, rd_key, v.exp_key);
    if (v.exp_err) exp_cnt++;
    @(posedge clk); #1;
    chk({nm, "_idle"}, 128'({busy, rd_done, wr_done}), 128'(0));
    chk_cnt(nm);
  endtask

  task automatic race(input logic w, input logic [1:0] r,
                      output int t_w, output int t_0, output int t_1);
    @(negedge clk);
    wr_req = w; wr_addr = 7'd10; wr_data = K1;
    rd_req = r; rd_addr = {7'd12, 7'd11};
    ram_valid = 1'b1; ram_ack = 1'b1; ram_key = K2;
    t_w = -1; t_0 = -1; t_1 = -1;
    for (int c = 1; c <= 14; c++) begin
      @(posedge clk); #1;
      if (wr_gnt)    begin t_w = c; wr_req    = 1'b0; end
      if (rd_gnt[0]) begin t_0 = c; rd_req[0] = 1'b0; end
      if (rd_gnt[1]) begin t_1 = c; rd_req[1] = 1'b0; end
    end
    wr_req = 1'b0; rd_req = 2'b00;
  endtask

  initial begin
    int tw, t0, t1;
    vecs[0] = mk(1, 2'b00, 7'd5,   K1, 1, '0, 0, 0, '0);
    vecs[1] = mk(0, 2'b01, 7'd5,   '0, 1, K1, 0, 0, K1);
    vecs[2] = mk(0, 2'b10, 7'd95,  '0, 1, K2, 1, 1, '0);
    vecs[3] = mk(1, 2'b00, 7'd5,   K3, 0, '0, 0, 1, '0);
    vecs[4] = mk(0, 2'b10, 7'd6,   '0, 1, K2, 0, 0, K2);
    vecs[5] = mk(0, 2'b01, 7'd32,  '0, 1, K3, 1, 1, '0);
    vecs[6] = mk(1, 2'b00, 7'd127, K1, 1, '0, 1, 1, '0);
    vecs[7] = mk(0, 2'b01, 7'd7,   '0, 0, K3, 0, 1, '0);
    vecs[8] = mk(0, 2'b10, 7'd126, '0, 1, K3, 0, 0, K3);
    vecs[9] = mk(1, 2'b00, 7'd0,   K2, 1, '0, 0, 0, K3);

    rst_n = 1'b0; rd_req = '0; rd_addr = '0; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    ram_key = '0; ram_valid = 1'b0; ram_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", 128'({rd_gnt, rd_done, rd_err, wr_gnt, wr_done, wr_err,
                            ram_ren, ram_wen, ram_addr, busy}), 128'(0));
    chk("reset_key", rd_key, '0);
    chk("reset_wdata", ram_wdata, '0);
    chk_cnt("reset");
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // Write plus both reads together: write first, then reads in rotation, 4 cycles apart.
    race(1'b1, 2'b11, tw, t0, t1);
    chk("race_wr_t",  128'(tw), 128'(1));
    chk("race_rd0_t", 128'(t0), 128'(5));
    chk("race_rd1_t", 128'(t1), 128'(9));
    race(1'b0, 2'b01, tw, t0, t1);
    chk("solo_rd0_t", 128'(t0), 128'(1));
    race(1'b0, 2'b11, tw, t0, t1);
    chk("rot_rd1_t", 128'(t1), 128'(1));
    chk("rot_rd0_t", 128'(t0), 128'(5));
    chk_cnt("race");

    // Reset while the RAM access is in WAIT: drop it silently, serve it again after release.
    @(negedge clk);
    rd_req = 2'b01; rd_addr = {7'd0, 7'd9}; ram_valid = 1'b1; ram_ack = 1'b0; ram_key = K2;
    @(posedge clk); #1;
    chk("rst_seq_gnt", 128'({rd_gnt, ram_ren}), 128'(3'b011));
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_async_outs", 128'({rd_gnt, rd_done, rd_err, wr_gnt, wr_done, ram_ren, ram_wen,
                                ram_addr, busy}), 128'(0));
    chk("rst_async_key", rd_key, '0);
    exp_cnt = 0;
    chk_cnt("rst_async");
    @(posedge clk); #1;
    chk("rst_no_done", 128'({rd_done, busy}), 128'(0));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rerun_gnt", 128'(rd_gnt), 128'(2'b01));
    rd_req = 2'b00;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rerun_done", 128'({rd_done, rd_err}), 128'(3'b010));
    chk("rerun_key", rd_key, K2);
    @(posedge clk); #1;
    chk_cnt("rerun");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
